// File: rtl/bypass_pkg.sv
// Shared definitions for the operand-forwarding network.
// Default geometry constants, stage indices and the destination-tag record.
package bypass_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned LANES  = 2;
  localparam int unsigned STAGES = 2;

  // Producer stage indices: youngest (MEM) and oldest (WB) stage after EX
  localparam int unsigned MEM_STG = 0;
  localparam int unsigned WB_STG  = STAGES - 1;

  // Destination tag carried alongside each in-flight result
  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] addr;
    logic              load;
  } tag_t;

  localparam int unsigned TAG_W = $bits(tag_t);

endpackage : bypass_pkg

// File: rtl/bypass_sel.sv
// Per-source priority mux: chooses the youngest matching producer result,
// or the register-file value when nothing matches. Purely combinational.
// A winning match on a load that has not yet reached WB is flagged as a
// hazard and the register-file value is passed through as a don't-care.
module bypass_sel
  import bypass_pkg::*;
#(
  parameter int unsigned XLEN   = bypass_pkg::XLEN,
  parameter int unsigned LANES  = bypass_pkg::LANES,
  parameter int unsigned STAGES = bypass_pkg::STAGES,
  parameter int unsigned REG_AW = bypass_pkg::REG_AW
) (
  input  logic                            rd_en,
  input  logic [REG_AW-1:0]               rd_addr,
  input  logic [XLEN-1:0]                 rf_data,
  input  logic [STAGES*LANES*TAG_W-1:0]   tags,
  input  logic [STAGES*LANES*XLEN-1:0]    stage_data,
  output logic [XLEN-1:0]                 op_data_c,
  output logic                            fwd_c,
  output logic                            hazard_c
);

  tag_t            tag;
  logic            hit;
  logic            hit_load;
  logic            hit_early;
  logic [XLEN-1:0] hit_data;

  // Scan oldest-to-youngest, lane-ascending; the last match written wins,
  // which gives lower stage first, then higher lane within a stage.
  always_comb begin
    tag       = '0;
    hit       = 1'b0;
    hit_load  = 1'b0;
    hit_early = 1'b0;
    hit_data  = '0;
    for (int s = int'(STAGES) - 1; s >= 0; s--) begin
      for (int l = 0; l < int'(LANES); l++) begin
        tag = stage_data_tag(s, l);
        if (rd_en && tag.vld && (tag.addr == rd_addr) && (rd_addr != '0)) begin
          hit       = 1'b1;
          hit_load  = tag.load;
          hit_early = (s < int'(STAGES) - 1);
          hit_data  = stage_data[(s*int'(LANES)+l)*int'(XLEN) +: XLEN];
        end
      end
    end
  end

  // Resolve the final operand and hazard from the winning match
  always_comb begin
    hazard_c  = hit & hit_load & hit_early;
    fwd_c     = hit & ~hazard_c;
    op_data_c = fwd_c ? hit_data : rf_data;
  end

  function automatic tag_t stage_data_tag(input int s, input int l);
    return tags[(s*int'(LANES)+l)*int'(TAG_W) +: TAG_W];
  endfunction

endmodule : bypass_sel

// File: rtl/bypass_net.sv
// Operand-forwarding network for an N-lane in-order core.
// Owns the MEM..WB destination-tag pipeline; the datapath supplies only the
// per-stage result data. Detects load-use hazards on still-pending loads.
// Optional feature macro: BYPASS_PERF_EN adds perf_hit_o / perf_haz_o
// cycle counters (forwarding cycles and hazard cycles).
module bypass_net
  import bypass_pkg::*;
#(
  parameter int unsigned XLEN   = bypass_pkg::XLEN,
  parameter int unsigned LANES  = bypass_pkg::LANES,
  parameter int unsigned STAGES = bypass_pkg::STAGES,
  parameter int unsigned REG_AW = bypass_pkg::REG_AW
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            stall_i,
  input  logic                            flush_i,
  input  logic [LANES-1:0]                ex_wr_en_i,
  input  logic [LANES*REG_AW-1:0]         ex_wr_addr_i,
  input  logic [LANES-1:0]                ex_is_load_i,
  input  logic [STAGES*LANES*XLEN-1:0]    stage_data_i,
  input  logic [LANES*2-1:0]              rd_en_i,
  input  logic [LANES*2*REG_AW-1:0]       rd_addr_i,
  input  logic [LANES*2*XLEN-1:0]         rf_data_i,
  output logic [LANES*2*XLEN-1:0]         op_data_o,
  output logic                            hazard_o
`ifdef BYPASS_PERF_EN
  ,
  output logic [31:0]                     perf_hit_o,
  output logic [31:0]                     perf_haz_o
`endif
);

  localparam int unsigned NSRC = LANES * 2;

  tag_t                          tag_q [STAGES][LANES];
  logic [STAGES*LANES*TAG_W-1:0] tag_flat;
  logic [NSRC-1:0]               src_fwd;
  logic [NSRC-1:0]               src_haz;

  // Tag pipeline: EX enters MEM unless stalled/flushed, older stages shift on
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < int'(STAGES); s++) begin
        for (int l = 0; l < int'(LANES); l++) begin
          tag_q[s][l] <= '0;
        end
      end
    end else begin
      for (int l = 0; l < int'(LANES); l++) begin
        tag_q[MEM_STG][l].vld  <= ex_wr_en_i[l] & ~stall_i & ~flush_i;
        tag_q[MEM_STG][l].addr <= ex_wr_addr_i[l*int'(REG_AW) +: REG_AW];
        tag_q[MEM_STG][l].load <= ex_is_load_i[l];
      end
      for (int s = 1; s < int'(STAGES); s++) begin
        for (int l = 0; l < int'(LANES); l++) begin
          tag_q[s][l] <= tag_q[s-1][l];
        end
      end
    end
  end

  // Flatten tags stage-major, lane-minor to match the stage data layout
  always_comb begin
    tag_flat = '0;
    for (int s = 0; s < int'(STAGES); s++) begin
      for (int l = 0; l < int'(LANES); l++) begin
        tag_flat[(s*int'(LANES)+l)*int'(TAG_W) +: TAG_W] = tag_q[s][l];
      end
    end
  end

  // One priority mux per consumer source
  for (genvar g = 0; g < int'(NSRC); g++) begin : g_src
    bypass_sel #(
      .XLEN   (XLEN),
      .LANES  (LANES),
      .STAGES (STAGES),
      .REG_AW (REG_AW)
    ) u_sel (
      .rd_en      (rd_en_i[g]),
      .rd_addr    (rd_addr_i[g*REG_AW +: REG_AW]),
      .rf_data    (rf_data_i[g*XLEN +: XLEN]),
      .tags       (tag_flat),
      .stage_data (stage_data_i),
      .op_data_c  (op_data_o[g*XLEN +: XLEN]),
      .fwd_c      (src_fwd[g]),
      .hazard_c   (src_haz[g])
    );
  end

  assign hazard_o = |src_haz;

`ifdef BYPASS_PERF_EN
  // Cycle counters for forwarding activity and load-use hazards; wrap freely
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_hit_o <= '0;
      perf_haz_o <= '0;
    end else begin
      if (|src_fwd) perf_hit_o <= perf_hit_o + 32'd1;
      if (hazard_o) perf_haz_o <= perf_haz_o + 32'd1;
    end
  end
`else
  // Forward indications only feed the counters; keep them observed
  logic unused_fwd;
  assign unused_fwd = ^src_fwd;
`endif

endmodule : bypass_net

// File: tb/tb_bypass_net.sv
// Directed, table-driven bench for bypass_net (default geometry).
// Inputs change on the falling edge; outputs are checked 1ns later, so each
// row observes the tags captured at earlier rising edges. The EX fields of a
// row are captured at the rising edge that follows its check.
module tb_bypass_net;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         stall_i;
  logic         flush_i;
  logic [1:0]   ex_wr_en_i;
  logic [9:0]   ex_wr_addr_i;
  logic [1:0]   ex_is_load_i;
  logic [127:0] stage_data_i;
  logic [3:0]   rd_en_i;
  logic [19:0]  rd_addr_i;
  logic [127:0] rf_data_i;
  logic [127:0] op_data_o;
  logic         hazard_o;
`ifdef BYPASS_PERF_EN
  logic [31:0]  perf_hit_o;
  logic [31:0]  perf_haz_o;
`endif

  bypass_net dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .ex_wr_en_i   (ex_wr_en_i),
    .ex_wr_addr_i (ex_wr_addr_i),
    .ex_is_load_i (ex_is_load_i),
    .stage_data_i (stage_data_i),
    .rd_en_i      (rd_en_i),
    .rd_addr_i    (rd_addr_i),
    .rf_data_i    (rf_data_i),
    .op_data_o    (op_data_o),
    .hazard_o     (hazard_o)
`ifdef BYPASS_PERF_EN
    ,
    .perf_hit_o   (perf_hit_o),
    .perf_haz_o   (perf_haz_o)
`endif
  );

  always #5 clk = ~clk;

  // Register-file value per source (src2 = lane1 rs1)
  localparam logic [31:0] RF0 = 32'h0000_0F00;
  localparam logic [31:0] RF1 = 32'h0000_0F01;
  localparam logic [31:0] RF2 = 32'h0000_DEAD;
  localparam logic [31:0] RF3 = 32'h0000_0F03;
  localparam logic [127:0] RF = {RF3, RF2, RF1, RF0};
  // Stage data: D<stage><lane>
  localparam logic [31:0] D00 = 32'h0000_1111;
  localparam logic [31:0] D01 = 32'h0000_2222;
  localparam logic [31:0] D10 = 32'h0000_3333;
  localparam logic [31:0] D11 = 32'h0000_4444;
  localparam logic [127:0] SD_DEF = {D11, D10, D01, D00};
  localparam logic [127:0] SD_ABC = {32'h0000_000D, 32'h0000_000C, 32'h0000_000B, 32'h0000_000A};

  typedef struct {
    string        nm;
    bit           st;
    bit           fl;
    bit [1:0]     wen;
    bit [1:0]     ld;
    bit [9:0]     wa;
    bit [3:0]     ren;
    bit [19:0]    ra;
    bit [127:0]   sd;
    bit [127:0]   eop;
    bit           ehaz;
  } vec_t;

  vec_t vecs [13];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input string nm, input bit st, input bit fl,
                              input bit [1:0] wen, input bit [1:0] ld, input bit [9:0] wa,
                              input bit [3:0] ren, input bit [19:0] ra, input bit [127:0] sd,
                              input bit [127:0] eop, input bit ehaz);
    vec_t v;
    v.nm = nm; v.st = st; v.fl = fl; v.wen = wen; v.ld = ld; v.wa = wa;
    v.ren = ren; v.ra = ra; v.sd = sd; v.eop = eop; v.ehaz = ehaz;
    return v;
  endfunction

  task automatic drive(input bit st, input bit fl, input bit [1:0] wen, input bit [1:0] ld,
                       input bit [9:0] wa, input bit [3:0] ren, input bit [19:0] ra,
                       input bit [127:0] sd);
    @(negedge clk);
    stall_i      = st;
    flush_i      = fl;
    ex_wr_en_i   = wen;
    ex_is_load_i = ld;
    ex_wr_addr_i = wa;
    rd_en_i      = ren;
    rd_addr_i    = ra;
    stage_data_i = sd;
  endtask

  task automatic chk(input string nm, input bit [127:0] eop, input bit ehaz);
    #1;
    n_chk++;
    if (op_data_o !== eop) begin
      n_fail++;
      $display("FAIL %s op: got %h want %h", nm, op_data_o, eop);
    end
    n_chk++;
    if (hazard_o !== ehaz) begin
      n_fail++;
      $display("FAIL %s hazard: got %b want %b", nm, hazard_o, ehaz);
    end
  endtask

`ifdef BYPASS_PERF_EN
  task automatic chk_perf(input string nm, input bit [31:0] ehit, input bit [31:0] ehaz);
    n_chk++;
    if (perf_hit_o !== ehit) begin
      n_fail++;
      $display("FAIL %s perf_hit: got %0d want %0d", nm, perf_hit_o, ehit);
    end
    n_chk++;
    if (perf_haz_o !== ehaz) begin
      n_fail++;
      $display("FAIL %s perf_haz: got %0d want %0d", nm, perf_haz_o, ehaz);
    end
  endtask
`endif

  initial begin
    // name, stall, flush, ex_wr_en, ex_is_load, {wa1,wa0}, rd_en, {a3,a2,a1,a0}, stage data, exp op, exp hazard
    vecs[0]  = mk("reset",       0, 0, 2'b01, 2'b00, {5'd0, 5'd5}, 4'b1111, {5'd5, 5'd5, 5'd5, 5'd5}, SD_DEF, RF, 0);
    vecs[1]  = mk("fwd_x5",      0, 0, 2'b01, 2'b00, {5'd0, 5'd7}, 4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, SD_DEF, {RF3, D00, RF1, RF0}, 0);
    vecs[2]  = mk("stage_prio",  0, 0, 2'b11, 2'b00, {5'd7, 5'd7}, 4'b1111, {5'd9, 5'd0, 5'd7, 5'd5}, SD_DEF, {RF3, RF2, D00, D10}, 0);
    vecs[3]  = mk("same_addr",   0, 0, 2'b11, 2'b00, {5'd0, 5'd0}, 4'b0011, {5'd3, 5'd7, 5'd7, 5'd7}, SD_ABC, {RF3, RF2, 32'h0000_000B, 32'h0000_000B}, 0);
    vecs[4]  = mk("x0_never",    0, 0, 2'b01, 2'b01, {5'd0, 5'd9}, 4'b1111, {5'd7, 5'd0, 5'd0, 5'd0}, SD_DEF, {D11, RF2, RF1, RF0}, 0);
    vecs[5]  = mk("load_use",    1, 0, 2'b11, 2'b00, {5'd9, 5'd9}, 4'b0011, {5'd9, 5'd9, 5'd9, 5'd0}, SD_DEF, RF, 1);
    vecs[6]  = mk("load_wb",     0, 1, 2'b11, 2'b00, {5'd3, 5'd3}, 4'b0010, {5'd0, 5'd0, 5'd9, 5'd0}, SD_DEF, {RF3, RF2, D10, RF0}, 0);
    vecs[7]  = mk("flush",       1, 1, 2'b11, 2'b00, {5'd3, 5'd3}, 4'b1001, {5'd9, 5'd0, 5'd0, 5'd3}, SD_DEF, RF, 0);
    vecs[8]  = mk("stall_flush", 0, 0, 2'b10, 2'b10, {5'd6, 5'd0}, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, SD_DEF, RF, 0);
    vecs[9]  = mk("lane1_load",  0, 0, 2'b01, 2'b00, {5'd0, 5'd6}, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd6}, SD_DEF, RF, 1);
    vecs[10] = mk("young_alu",   0, 0, 2'b01, 2'b01, {5'd0, 5'd6}, 4'b0100, {5'd0, 5'd6, 5'd0, 5'd0}, SD_DEF, {RF3, D00, RF1, RF0}, 0);
    vecs[11] = mk("young_load",  0, 0, 2'b00, 2'b00, {5'd0, 5'd0}, 4'b0100, {5'd0, 5'd6, 5'd0, 5'd0}, SD_DEF, RF, 1);
    vecs[12] = mk("wb_load",     0, 0, 2'b00, 2'b00, {5'd0, 5'd0}, 4'b0100, {5'd0, 5'd6, 5'd0, 5'd0}, SD_DEF, {RF3, D10, RF1, RF0}, 0);

    rst_i        = 1'b1;
    stall_i      = 1'b0;
    flush_i      = 1'b0;
    ex_wr_en_i   = '0;
    ex_wr_addr_i = '0;
    ex_is_load_i = '0;
    stage_data_i = '0;
    rd_en_i      = '0;
    rd_addr_i    = '0;
    rf_data_i    = RF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;

`ifdef BYPASS_PERF_EN
    #1;
    chk_perf("perf_after_reset", 32'd0, 32'd0);
`endif

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].st, vecs[i].fl, vecs[i].wen, vecs[i].ld, vecs[i].wa,
            vecs[i].ren, vecs[i].ra, vecs[i].sd);
      chk(vecs[i].nm, vecs[i].eop, vecs[i].ehaz);
    end

    // Reset in the middle of a forwarding window drops the in-flight tag
    drive(0, 0, 2'b01, 2'b00, {5'd0, 5'd5}, 4'b0000, 20'd0, SD_DEF);
    chk("pre_rst_idle", RF, 0);
    drive(0, 0, 2'b01, 2'b00, {5'd0, 5'd5}, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, SD_DEF);
    chk("pre_rst_fwd", {RF3, RF2, RF1, D00}, 0);
    drive(0, 0, 2'b01, 2'b00, {5'd0, 5'd5}, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, SD_DEF);
    rst_i = 1'b1;
    drive(0, 0, 2'b00, 2'b00, 10'd0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, SD_DEF);
    rst_i = 1'b0;
    chk("post_rst", RF, 0);

`ifdef BYPASS_PERF_EN
    chk_perf("perf_mid_rst", 32'd0, 32'd0);
    // Put x5 into MEM, then five forwarding cycles, then two load-use cycles
    drive(0, 0, 2'b01, 2'b00, {5'd0, 5'd5}, 4'b0000, 20'd0, SD_DEF);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 2'b01, 2'b00, {5'd0, 5'd5}, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, SD_DEF);
    end
    drive(0, 0, 2'b01, 2'b01, {5'd0, 5'd8}, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, SD_DEF);
    chk("perf_hit5", {RF3, RF2, RF1, D00}, 0);
    drive(0, 0, 2'b01, 2'b01, {5'd0, 5'd8}, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd8}, SD_DEF);
    chk("perf_haz1", RF, 1);
    drive(0, 0, 2'b00, 2'b00, 10'd0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd8}, SD_DEF);
    chk("perf_haz2", RF, 1);
    drive(0, 0, 2'b00, 2'b00, 10'd0, 4'b0000, 20'd0, SD_DEF);
    #1;
    chk_perf("perf_counts", 32'd5, 32'd2);
    drive(0, 0, 2'b00, 2'b00, 10'd0, 4'b0000, 20'd0, SD_DEF);
    rst_i = 1'b1;
    drive(0, 0, 2'b00, 2'b00, 10'd0, 4'b0000, 20'd0, SD_DEF);
    rst_i = 1'b0;
    #1;
    chk_perf("perf_cleared", 32'd0, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_bypass_net
